// File: rtl/fetch_unit.sv
// fetch_unit: issues sequential instruction reads to a 1-cycle memory and queues the words for decode.
// Build option FETCH_BUFFER_EN: 2-entry buffer (1 instruction/cycle); default is 1 entry.
// Handshake: an instruction moves to decode in any cycle with inst_valid=1 and inst_ready=1;
// inst_valid never depends on inst_ready, and the head entry holds steady until it is taken.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        run,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        MemRead,
  output logic [15:0] ADDR,
  output logic        MemWrite,
  input  logic [15:0] Data_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  output logic [1:0]  o_state
);

`ifdef FETCH_BUFFER_EN
  localparam logic [1:0] CAP = 2'd2;
`else
  localparam logic [1:0] CAP = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state, w_next_state;
  logic [15:0] r_pc, w_next_pc;
  logic        r_inflight;
  logic [15:0] r_inflight_pc;
  logic [15:0] r_buf_data [0:1];
  logic [15:0] r_buf_pc   [0:1];
  logic [1:0]  r_count;

  logic        w_pop, w_flush, w_issue, w_push;
  logic [1:0]  w_cnt_after_pop, w_occ;

  // A pop in this cycle frees its slot for an issue in the same cycle.
  assign w_pop           = (r_count != 2'd0) && inst_ready;
  assign w_flush         = redirect && (r_state != IDLE);
  assign w_cnt_after_pop = r_count - {1'b0, w_pop};
  assign w_occ           = w_cnt_after_pop + {1'b0, r_inflight};
  assign w_push          = r_inflight && !w_flush;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect) w_next_pc = redirect_pc;
        if (run) w_next_state = FETCH;
      end
      FETCH, FULL: begin
        if (w_flush) begin
          w_next_pc    = redirect_pc;
          w_next_state = run ? FETCH : HALT;
        end else if (!run) begin
          w_next_state = HALT;
        end else begin
          w_issue      = (w_occ < CAP);
          w_next_state = ((w_occ + {1'b0, w_issue}) >= CAP) ? FULL : FETCH;
          if (w_issue) w_next_pc = r_pc + PC_STEP;
        end
      end
      HALT: begin
        if (w_flush) begin
          w_next_pc    = redirect_pc;
          w_next_state = run ? FETCH : HALT;
        end else if (run) begin
          w_next_state = FETCH;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 16'h0000;
      r_count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= 16'h0000;
        r_buf_pc[i]   <= 16'h0000;
      end
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_inflight    <= w_issue;
      r_inflight_pc <= r_pc;
      if (w_flush) begin
        r_count <= 2'd0;
      end else begin
        // Shift-register FIFO: entry 0 is always the head.
        if (w_pop) begin
          r_buf_data[0] <= r_buf_data[1];
          r_buf_pc[0]   <= r_buf_pc[1];
        end
        if (w_push) begin
          r_buf_data[w_cnt_after_pop[0]] <= Data_out;
          r_buf_pc[w_cnt_after_pop[0]]   <= r_inflight_pc;
        end
        r_count <= w_cnt_after_pop + {1'b0, w_push};
      end
    end
  end

  assign MemRead    = w_issue;
  assign ADDR       = r_pc;
  assign MemWrite   = 1'b0;
  assign inst_valid = (r_count != 2'd0);
  assign inst_data  = r_buf_data[0];
  assign inst_pc    = r_buf_pc[0];
  assign o_state    = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, expected {pc,data} pushed to queues, monitors pop on each transfer.
module tb_fetch_unit;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;
`ifdef FETCH_BUFFER_EN
  localparam int CAP = 2;
  localparam int GAP = 1;
`else
  localparam int CAP = 1;
  localparam int GAP = 2;
`endif

  // clock / reset
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  always #5 CLK = ~CLK;

  logic        run = 1'b0, redirect = 1'b0, inst_ready = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        MemRead, MemWrite, inst_valid;
  logic [15:0] ADDR, inst_data, inst_pc;
  logic [15:0] Data_out = 16'h0000;
  logic [1:0]  o_state;

  logic        run2 = 1'b0, redirect2 = 1'b0, inst_ready2 = 1'b0;
  logic [15:0] redirect_pc2 = 16'h0000;
  logic        MemRead2, MemWrite2, inst_valid2;
  logic [15:0] ADDR2, inst_data2, inst_pc2;
  logic [15:0] Data_out2 = 16'h0000;
  logic [1:0]  o_state2;

  fetch_unit u_dut (
    .CLK(CLK), .reset(reset), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
    .MemRead(MemRead), .ADDR(ADDR), .MemWrite(MemWrite), .Data_out(Data_out),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .o_state(o_state)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_dut2 (
    .CLK(CLK), .reset(reset), .run(run2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .MemRead(MemRead2), .ADDR(ADDR2), .MemWrite(MemWrite2), .Data_out(Data_out2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_data(inst_data2),
    .inst_pc(inst_pc2), .o_state(o_state2)
  );

  // memory model: 1-cycle read, junk when not reading
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      16'h0003: return 16'h4444;
      default:  return a ^ 16'hA500;
    endcase
  endfunction

  always @(posedge CLK) begin
    Data_out  <= MemRead  ? mem_word(ADDR)  : 16'hDEAD;
    Data_out2 <= MemRead2 ? mem_word(ADDR2) : 16'hDEAD;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] exp_e, exp2_e;
  int acc_cnt = 0, acc2_cnt = 0, rd_cnt = 0;
  int acc_cyc[64];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (MemRead) rd_cnt++;
    if (inst_valid && inst_ready) begin
      if (acc_cnt < 64) acc_cyc[acc_cnt] = cyc;
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver unexpected pc %h data %h, required none", inst_pc, inst_data);
      end else begin
        exp_e = exp_q.pop_front();
        chk("deliver", {inst_pc, inst_data}, exp_e);
      end
    end
    if (inst_valid2 && inst_ready2) begin
      acc2_cnt++;
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deliver2 unexpected pc %h data %h, required none", inst_pc2, inst_data2);
      end else begin
        exp2_e = exp2_q.pop_front();
        chk("deliver2", {inst_pc2, inst_data2}, exp2_e);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    run = 1'b0; run2 = 1'b0; redirect = 1'b0; redirect2 = 1'b0;
    inst_ready = 1'b0; inst_ready2 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_acc(input bit sel, input int target, input int budget);
    bit done;
    int cnt;
    done = 1'b0;
    cnt = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK);
      #1;
      cnt = sel ? acc2_cnt : acc_cnt;
      if (cnt >= target) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_acc timeout accepted %0d required %0d", cnt, target);
    end
  endtask

  int a0, base, rd0;
  bit found;

  initial begin
    // reset state
    reset_dut();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_memread", {31'd0, MemRead}, 32'd0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_data_pc", {inst_pc, inst_data}, 32'd0);
    chk("rst_addr", {16'd0, ADDR}, 32'h0000_0000);
    chk("rst_state", {30'd0, o_state}, {30'd0, ST_IDLE});
    chk("rst_addr2", {16'd0, ADDR2}, 32'h0000_FFFF);

    // streaming with decode always ready
    reset_dut();
    a0 = cyc;
    base = acc_cnt;
    run = 1'b1;
    inst_ready = 1'b1;
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0001, 16'h2222});
    exp_q.push_back({16'h0002, 16'h3333});
    exp_q.push_back({16'h0003, 16'h4444});
    wait_acc(1'b0, base + 4, 40);
    chk("first_latency", acc_cyc[base] - a0, 32'd3);
    for (int i = 0; i < 3; i++) chk("throughput_gap", acc_cyc[base + i + 1] - acc_cyc[base + i], GAP);
    chk("drain_stream", exp_q.size(), 32'd0);

    // backpressure: decode stalls for 5 cycles after the first issue
    reset_dut();
    run = 1'b1;
    inst_ready = 1'b0;
    rd0 = rd_cnt;
    @(negedge CLK);
    chk("idle_no_read", {31'd0, MemRead}, 32'd0);
    tick();
    @(negedge CLK);
    chk("first_issue", {15'd0, MemRead, ADDR}, {15'd0, 1'b1, 16'h0000});
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("stall_head", {15'd0, inst_valid, inst_data}, {15'd0, 1'b1, 16'h1111});
      tick();
    end
    chk("stall_reads", rd_cnt - rd0, CAP);
    chk("stall_memread", {31'd0, MemRead}, 32'd0);
    chk("stall_state", {30'd0, o_state}, {30'd0, ST_FULL});
    base = acc_cnt;
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0001, 16'h2222});
    exp_q.push_back({16'h0002, 16'h3333});
    exp_q.push_back({16'h0003, 16'h4444});
    inst_ready = 1'b1;
    wait_acc(1'b0, base + 4, 40);
    chk("drain_stall", exp_q.size(), 32'd0);

    // redirect the cycle after the read of 0002
    reset_dut();
    base = acc_cnt;
    run = 1'b1;
    inst_ready = 1'b1;
    exp_q.push_back({16'h0000, 16'h1111});
    exp_q.push_back({16'h0001, 16'h2222});
    exp_q.push_back({16'h0008, 16'hA508});
    exp_q.push_back({16'h0009, 16'hA509});
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (MemRead && ADDR == 16'h0002) begin
        found = 1'b1;
        break;
      end
    end
    chk("issue_0002_seen", {31'd0, found}, 32'd1);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0008;
    @(negedge CLK);
    chk("redirect_no_read", {31'd0, MemRead}, 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge CLK);
    chk("redirect_flush", {31'd0, inst_valid}, 32'd0);
    wait_acc(1'b0, base + 4, 40);
    chk("drain_redirect", exp_q.size(), 32'd0);

    // run drops with one read in flight
    reset_dut();
    base = acc_cnt;
    run = 1'b1;
    inst_ready = 1'b0;
    rd0 = rd_cnt;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    tick();
    chk("halt_reads", rd_cnt - rd0, 32'd1);
    chk("halt_state", {30'd0, o_state}, {30'd0, ST_HALT});
    chk("halt_valid", {15'd0, inst_valid, inst_pc}, {15'd0, 1'b1, 16'h0000});
    exp_q.push_back({16'h0000, 16'h1111});
    inst_ready = 1'b1;
    wait_acc(1'b0, base + 1, 10);
    tick();
    tick();
    chk("halt_no_more_reads", rd_cnt - rd0, 32'd1);
    chk("halt_empty", {31'd0, inst_valid}, 32'd0);
    exp_q.push_back({16'h0001, 16'h2222});
    exp_q.push_back({16'h0002, 16'h3333});
    run = 1'b1;
    wait_acc(1'b0, base + 3, 30);
    chk("drain_halt", exp_q.size(), 32'd0);

    // reset with the buffer full, then redirect while idle
    reset_dut();
    run = 1'b1;
    inst_ready = 1'b0;
    repeat (6) tick();
    chk("full_before_reset", {31'd0, inst_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_full_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_full_memread", {31'd0, MemRead}, 32'd0);
    chk("reset_full_addr", {16'd0, ADDR}, 32'h0000_0000);
    chk("reset_full_state", {30'd0, o_state}, {30'd0, ST_IDLE});
    run = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    chk("idle_redirect_state", {30'd0, o_state}, {30'd0, ST_IDLE});
    chk("idle_redirect_addr", {15'd0, MemRead, ADDR}, {15'd0, 1'b0, 16'h0010});

    // PC wrap from RESET_PC = FFFF
    reset_dut();
    base = acc2_cnt;
    exp2_q.push_back({16'hFFFF, 16'h5AFF});
    exp2_q.push_back({16'h0000, 16'h1111});
    run2 = 1'b1;
    inst_ready2 = 1'b1;
    wait_acc(1'b1, base + 2, 30);
    chk("drain_wrap", exp2_q.size(), 32'd0);
    reset_dut();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
